// File: rtl/rw_bit_collector_pkg.sv
// Shared types and sizing constants for the ReWire serial bit collector.
// Default word/depth sizes and derived counter widths.
package rw_bit_collector_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_DEPTH  = 4;

  typedef logic [DEF_WORD_W-1:0] word_t;

  localparam int CNT_W = $clog2(DEF_WORD_W);
  localparam int LVL_W = $clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/rw_fwft_fifo.sv
// Generic first-word-fall-through FIFO with occupancy counter.
// Ports: push/din in, pop in, dout (0 when empty), empty, full, level.
module rw_fwft_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wPtr;
  logic [AW-1:0] rPtr;
  logic [LW-1:0] cnt;
  logic          popOk;
  logic          pushOk;

  assign empty  = (cnt == '0);
  assign full   = (cnt == LW'(DEPTH));
  assign popOk  = pop && !empty;
  // a full FIFO still accepts a word when the head leaves on the same edge
  assign pushOk = push && (!full || popOk);
  assign dout   = empty ? '0 : mem[rPtr];
  assign level  = cnt;

  always_ff @(posedge clk) begin
    if (pushOk) mem[wPtr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtr <= '0;
      rPtr <= '0;
      cnt  <= '0;
    end else begin
      if (pushOk) wPtr <= wPtr + AW'(1);
      if (popOk)  rPtr <= rPtr + AW'(1);
      unique case ({pushOk, popOk})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rw_bit_collector.sv
// Collects a qualified serial bit stream into words and queues them.
// Ports: bit_in/bit_valid/sync_clr in; word_* valid/ready out; level, overflow.
module rw_bit_collector
  import rw_bit_collector_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     sync_clr,
  output logic [WORD_W-1:0]        word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int CW = $clog2(WORD_W);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     bitCnt;
  logic [WORD_W-1:0] shiftReg;
  logic [WORD_W-1:0] nextWord;
  logic [WORD_W-1:0] freshWord;
  logic              lastBit;
  logic              pushWord;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              dropWord;

  always_comb begin
    nextWord  = '0;
    freshWord = '0;
    if (MSB_FIRST) begin
      nextWord     = {shiftReg[WORD_W-2:0], bit_in};
      freshWord[0] = bit_in;
    end else begin
      nextWord            = {bit_in, shiftReg[WORD_W-1:1]};
      freshWord[WORD_W-1] = bit_in;
    end
  end

  assign lastBit  = (bitCnt == CW'(WORD_W - 1));
  // resync takes priority: the bit on that edge starts a new word
  assign pushWord = bit_valid && !sync_clr && lastBit;
  assign dropWord = pushWord && fifoFull && !word_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCnt   <= '0;
      shiftReg <= '0;
    end else if (sync_clr) begin
      bitCnt   <= bit_valid ? CW'(1) : '0;
      shiftReg <= bit_valid ? freshWord : '0;
    end else if (bit_valid) begin
      bitCnt   <= lastBit ? '0 : bitCnt + CW'(1);
      shiftReg <= nextWord;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (dropWord)     overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  rw_fwft_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pushWord),
    .din   (nextWord),
    .pop   (word_ready),
    .dout  (word_data),
    .empty (fifoEmpty),
    .full  (fifoFull),
    .level (level)
  );

  assign word_valid = !fifoEmpty;

endmodule

// File: tb/tb_rw_bit_collector.sv
// Directed bench for rw_bit_collector with a word scoreboard.
// Drives an MSB-first and an LSB-first instance from the same stimulus.
module tb_rw_bit_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sync_clr = 1'b0;
  logic       word_ready = 1'b0;
  logic       clr_overflow = 1'b0;

  logic [7:0] wdM, wdL;
  logic       wvM, wvL;
  logic [2:0] lvlM, lvlL;
  logic       ovfM, ovfL;

  int passCnt = 0;
  int failCnt = 0;
  int totCnt  = 0;

  logic [7:0] expQ [$];

  always #5 clk = ~clk;

  rw_bit_collector #(.WORD_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) dutM (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .sync_clr(sync_clr), .word_data(wdM), .word_valid(wvM),
    .word_ready(word_ready), .level(lvlM), .overflow(ovfM),
    .clr_overflow(clr_overflow)
  );

  rw_bit_collector #(.WORD_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) dutL (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .sync_clr(sync_clr), .word_data(wdL), .word_valid(wvL),
    .word_ready(word_ready), .level(lvlL), .overflow(ovfL),
    .clr_overflow(clr_overflow)
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    totCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every accepted head word is compared against the queue
  always @(negedge clk) begin
    if (wvM && word_ready) begin
      if (expQ.size() == 0) begin
        check("pop_unexpected", 32'(wdM), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        check("pop_msb", 32'(wdM), 32'(e));
        check("pop_lsb", 32'(wdL), 32'(rev8(e)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sendBit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      sendBit(w[i]);
      if (i > 0) idle(gap);
    end
  endtask

  task automatic send7(input logic [7:0] w);
    for (int i = 7; i >= 1; i--) sendBit(w[i]);
  endtask

  initial begin
    idle(2);
    check("rst_valid", 32'(wvM), 32'd0);
    check("rst_data", 32'(wdM), 32'd0);
    check("rst_level", 32'(lvlM), 32'd0);
    check("rst_ovf", 32'(ovfM), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // basic word, back-to-back bits
    word_ready = 1'b1;
    expQ.push_back(8'hD0);
    sendWord(8'hD0, 0);
    check("w1_valid", 32'(wvM), 32'd1);
    check("w1_msb", 32'(wdM), 32'hD0);
    check("w1_lsb", 32'(wdL), 32'h0B);
    step();
    check("w1_pulse", 32'(wvM), 32'd0);
    check("w1_zero", 32'(wdM), 32'd0);

    // idle cycles between bits do not disturb the count
    expQ.push_back(8'hD0);
    sendWord(8'hD0, 2);
    check("w2_msb", 32'(wdM), 32'hD0);
    check("w2_lsb", 32'(wdL), 32'h0B);
    step();

    // overflow: five words into four slots
    word_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expQ.push_back(8'(k));
      sendWord(8'(k), 0);
    end
    check("ovf_level", 32'(lvlM), 32'd4);
    check("ovf_flag", 32'(ovfM), 32'd1);
    check("ovf_head", 32'(wdM), 32'h01);
    check("ovf_lsb_lvl", 32'(lvlL), 32'd4);
    word_ready = 1'b1;
    idle(4);
    word_ready = 1'b0;
    check("drain_level", 32'(lvlM), 32'd0);
    check("drain_valid", 32'(wvM), 32'd0);
    check("drain_data", 32'(wdM), 32'd0);
    check("drain_ovf", 32'(ovfM), 32'd1);
    idle(1);
    check("ready_empty", 32'(lvlM), 32'd0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_clr", 32'(ovfM), 32'd0);

    // set beats a same-edge clear
    for (int k = 1; k <= 4; k++) begin
      expQ.push_back(8'(k + 16));
      sendWord(8'(k + 16), 0);
    end
    send7(8'h77);
    clr_overflow = 1'b1;
    sendBit(1'b1);
    clr_overflow = 1'b0;
    check("ovf_setwins", 32'(ovfM), 32'd1);
    word_ready = 1'b1;
    idle(4);
    word_ready = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_clr2", 32'(ovfM), 32'd0);

    // full FIFO with a pop on the completing edge
    for (int k = 1; k <= 4; k++) begin
      expQ.push_back(8'(k * 17));
      sendWord(8'(k * 17), 0);
    end
    check("full_level", 32'(lvlM), 32'd4);
    expQ.push_back(8'hAA);
    send7(8'hAA);
    word_ready = 1'b1;
    sendBit(1'b0);
    word_ready = 1'b0;
    check("popfull_level", 32'(lvlM), 32'd4);
    check("popfull_ovf", 32'(ovfM), 32'd0);
    check("popfull_head", 32'(wdM), 32'h22);
    word_ready = 1'b1;
    idle(4);
    check("popfull_drain", 32'(lvlM), 32'd0);

    // resync mid-word
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    expQ.push_back(8'h81);
    sync_clr = 1'b1;
    sendBit(1'b1);
    sync_clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sendBit(i == 6);
      if (i == 3) check("sync_nopartial", 32'(wvM), 32'd0);
    end
    check("sync_msb", 32'(wdM), 32'h81);
    check("sync_lsb", 32'(wdL), 32'h81);
    step();

    // asynchronous reset mid-word with two words queued
    word_ready = 1'b0;
    sendWord(8'h3C, 0);
    sendWord(8'hC3, 0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b1);
    check("pre_rst_level", 32'(lvlM), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(wvM), 32'd0);
    check("arst_level", 32'(lvlM), 32'd0);
    check("arst_ovf", 32'(ovfM), 32'd0);
    check("arst_data", 32'(wdM), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    word_ready = 1'b1;
    expQ.push_back(8'h5A);
    sendWord(8'h5A, 0);
    check("post_rst_msb", 32'(wdM), 32'h5A);
    check("post_rst_lsb", 32'(wdL), 32'h5A);
    idle(2);
    check("sb_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule

// File: doc/rw_bit_collector.md
Name: rw_bit_collector

Overview:
- Downstream consumer of the 1-bit serial output of a ReWire-generated top_level device.
- Gathers bits, qualified by a valid strobe, into WORD_W-bit words and buffers them in a small first-word-fall-through FIFO.
- Presents the buffered words on a valid/ready interface to the host-side logic.
- Detects FIFO overflow with a sticky flag. Supports resynchronisation of the word boundary without flushing buffered words.

Parameters:
- WORD_W, 8, bits per assembled word (≥2).
- DEPTH, 4, FIFO depth in words (power of 2, ≥2).
- MSB_FIRST, 1, 1 = first received bit lands in word bit WORD_W-1; 0 = first bit lands in bit 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- bit_in  in  1  serial data bit (device __out0)
- bit_valid  in  1  bit_in is sampled on this edge
- sync_clr  in  1  restart word assembly at bit index 0
- word_data  out  WORD_W  FIFO head word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts head word this cycle
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky: a completed word was dropped
- clr_overflow  in  1  clears overflow

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. Reset clears:
  - bit counter, shift register, FIFO pointers, level, overflow
  - word_valid=0, word_data=0, level=0, overflow=0
- Assembly:
  - bit counter cnt runs 0..WORD_W-1.
  - On each clk edge with bit_valid=1, bit_in is shifted into the assembly register and cnt increments.
  - With MSB_FIRST=1 the register shifts left and takes bit_in at the LSB; with MSB_FIRST=0 it shifts right and takes bit_in at the MSB.
- Word completion:
  - When bit_valid=1 and cnt=WORD_W-1, the word including the current bit is pushed to the FIFO and cnt wraps to 0.
  - Latency: word_valid/word_data reflect the new word the cycle after the edge that samples the last bit, if the FIFO was empty.
- sync_clr:
  - cnt←0 and the partial word is discarded. FIFO contents are untouched.
  - If bit_valid=1 on the same edge, that bit becomes bit index 0 of the new word. sync_clr has priority over any completion.
- Pop: an edge with word_valid=1 and word_ready=1 removes the head. word_ready while empty is ignored.
- Push when full:
  - If a pop occurs on the same edge, the push is accepted and level stays DEPTH.
  - Otherwise the word is dropped, FIFO unchanged, overflow←1.
- Simultaneous push and pop when not full: level unchanged.
- overflow:
  - Set per the push-when-full rule above; cleared by clr_overflow.
  - Set wins over a same-cycle clr_overflow.
- word_data is 0 whenever word_valid=0. Otherwise it is the head entry, stable until popped.
- Pointers wrap modulo DEPTH. level is derived from a full-width counter, not pointer difference.
- Reset asserted mid-word or with a full FIFO: all state is discarded immediately. The first post-reset bit is bit index 0.
- All outputs are registered or directly derived from registered state. There are no combinational paths from bit_in/bit_valid to the outputs.

Decomposition:
- Package rw_bit_collector_pkg holds:
  - typedef word_t (logic [WORD_W-1:0]) built from a default WORD_W constant
  - localparam CNT_W = $clog2(WORD_W)
  - localparam LVL_W = $clog2(DEPTH)+1
- Sub-module rw_fwft_fifo: generic FWFT FIFO with push/pop/full/empty/level, parameterised on width and depth. Top level keeps the shift register, counter, sync and overflow logic.

Test Plan:
- WORD_W=8, MSB_FIRST=1; bits 1,1,0,1,0,0,0,0 on 8 consecutive valid cycles, word_ready=1 -> word_valid pulses for 1 cycle, word_data=8'hD0, one cycle after the 8th edge.
- Same bits with MSB_FIRST=0 -> word_data=8'h0B. Insert idle cycles (bit_valid=0) between bits -> same result; counter is unaffected by idle cycles.
- word_ready=0; push 5 words 8'h01..8'h05 with DEPTH=4 -> level=4, overflow=1, head=8'h01. Drain yields 01,02,03,04. clr_overflow -> overflow=0.
- FIFO full, word_ready=1 on the edge the 8th bit of word 8'hAA arrives -> head pops, 8'hAA accepted, level stays 4, overflow stays 0.
- After 3 bits, assert sync_clr with bit_valid=1, bit_in=1, then 7 more bits 0,0,0,0,0,0,1 -> word_data=8'h81 (MSB_FIRST=1); the partial word is never emitted.
- Assert rst after 5 bits with level=2 -> word_valid=0, level=0, overflow=0 asynchronously. The next 8 bits form a fresh word.
